// File: rtl/spi_flash_master_if.sv
// Command/response bus between the flash test controller and spi_flash_master.
interface spi_flash_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic       end_req;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_data, cmd_last, end_req,
        input  cmd_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_last, end_req,
        output cmd_ready, rx_valid, rx_data, busy
    );
endinterface

// File: rtl/spi_flash_master.sv
// Byte-level SPI mode-0 master for the M25P16 serial flash, with CS setup,
// hold and idle spacing counted in clk cycles.
module spi_flash_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_flash_master_if.slave bus,
    input  logic              wp_en,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_hold_n,
    output logic              spi_wp_n
);
    localparam int CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_END  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       tx_sr, tx_sr_d;
    logic [7:0]       rx_sr, rx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             last_q, last_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             rx_valid_q, rx_valid_d;
    logic             wp_n_q;
    logic             ready;

    // NOTE: every signal gets its default before the case, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state;
        cnt_d      = '0;
        bit_cnt_d  = bit_cnt;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        rx_valid_d = 1'b0;
        ready      = 1'b0;

        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    tx_sr_d = bus.cmd_data;
                    last_d  = bus.cmd_last;
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (cnt == SETUP_END) state_d = SHIFT;
                else                  cnt_d   = cnt + CNT_ONE;
            end

            SHIFT: begin
                if (cnt != DIV_END) begin
                    cnt_d = cnt + CNT_ONE;
                end else if (!sclk_q) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr[6:0], spi_miso};
                end else begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // mosi keeps the final bit through WAIT rather than shifting in a zero
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sr;
                        state_d    = last_q ? HOLD : WAIT;
                    end else begin
                        tx_sr_d = {tx_sr[6:0], 1'b0};
                    end
                end
            end

            WAIT: begin
                ready = !bus.end_req;
                if (bus.end_req) begin
                    state_d = HOLD;
                end else if (bus.cmd_valid) begin
                    tx_sr_d = bus.cmd_data;
                    last_d  = bus.cmd_last;
                    state_d = SHIFT;
                end
            end

            HOLD: begin
                if (cnt == HOLD_END) begin
                    cs_n_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end

            GAP: begin
                if (cnt == IDLE_END) state_d = IDLE;
                else                 cnt_d   = cnt + CNT_ONE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only, so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            wp_n_q     <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            tx_sr      <= tx_sr_d;
            rx_sr      <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            rx_valid_q <= rx_valid_d;
            wp_n_q     <= ~wp_en;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.busy      = (state != IDLE);

    // mosi is the shift register MSB, so it only moves when the byte shifts on sclk fall
    assign spi_cs_n   = cs_n_q;
    assign spi_sclk   = sclk_q;
    assign spi_mosi   = tx_sr[7];
    assign spi_hold_n = 1'b1;
    assign spi_wp_n   = wp_n_q;
endmodule

// File: tb/tb_spi_flash_master.sv
// Directed self-checking bench for spi_flash_master: a bench-side mode-0 slave
// returns scripted bytes while a monitor logs pin activity per clk cycle.
module tb_spi_flash_master;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic wp_en;
    logic spi_cs_n, spi_sclk, spi_mosi, spi_miso, spi_hold_n, spi_wp_n;

    spi_flash_master_if bus ();

    spi_flash_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .wp_en     (wp_en),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_hold_n(spi_hold_n),
        .spi_wp_n  (spi_wp_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Monitor state, written only by the monitor process.
    int         cyc = 0;
    int         cs_fall_cyc, cs_rise_cyc, cs_low_len, cs_fall_n;
    int         rise_cnt, fall_cnt, rx_cnt, hold_bad;
    int         rise_cyc [64];
    logic       rise_mosi[64];
    logic [7:0] rx_log   [64];
    logic       cs_prev   = 1'b1;
    logic       sclk_prev = 1'b0;

    // Slave model: shifts resp[] out MSB first, advancing on each sclk fall.
    int         fall_base = 0;
    logic [7:0] resp [0:7];
    int         miso_idx;
    logic [5:0] mi;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cyc >= 2) begin
            if (spi_cs_n !== cs_prev) begin
                if (spi_cs_n === 1'b0) begin
                    cs_fall_cyc = cyc;
                    cs_fall_n++;
                end else begin
                    cs_rise_cyc = cyc;
                    cs_low_len  = cyc - cs_fall_cyc;
                end
            end
            if (spi_sclk === 1'b1 && sclk_prev === 1'b0) begin
                rise_cyc[rise_cnt % 64]  = cyc;
                rise_mosi[rise_cnt % 64] = spi_mosi;
                rise_cnt++;
            end
            if (spi_sclk === 1'b0 && sclk_prev === 1'b1) fall_cnt++;
            if (bus.rx_valid === 1'b1) begin
                rx_log[rx_cnt % 64] = bus.rx_data;
                rx_cnt++;
            end
            if (spi_hold_n !== 1'b1) hold_bad++;
            cs_prev   = spi_cs_n;
            sclk_prev = spi_sclk;
        end
    end

    always_comb begin
        miso_idx = fall_cnt - fall_base;
        if (miso_idx < 0 || miso_idx > 63) miso_idx = 0;
        mi       = 6'(miso_idx);
        spi_miso = resp[mi[5:3]][3'd7 - mi[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mosi_byte(input int base);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = rise_mosi[(base + i) % 64];
        return v;
    endfunction

    // Presents one byte, returns the clk edge number on which it was accepted.
    task automatic send(input logic [7:0] d, input logic l, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_last  = l;
        #1;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_accept_in_time", 32'(n < 2000), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 3000), 1);
    endtask

    initial begin
        int acc1, acc2, n, bad, h_edge, f0, base_r, base_x;

        rst_n         = 1'b0;
        wp_en         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_last  = 1'b0;
        bus.end_req   = 1'b0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_cs_n",     spi_cs_n,     1);
        check("rst_sclk",     spi_sclk,     0);
        check("rst_mosi",     spi_mosi,     0);
        check("rst_hold_n",   spi_hold_n,   1);
        check("rst_wp_n",     spi_wp_n,     1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data",  bus.rx_data,  0);
        check("rst_busy",     bus.busy,     0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);
        check("idle_busy",      bus.busy,      0);
        check("idle_cs_n",      spi_cs_n,      1);

        // Single-byte 0x9F, slave answers 0xA5; then an immediate follow-up byte
        resp[0]   = 8'hA5;
        resp[1]   = 8'h5C;
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        base_x    = rx_cnt;
        send(8'h9F, 1'b1, acc1);
        check("t2_cs_low_on_accept_edge", cs_fall_cyc, acc1);
        send(8'h05, 1'b1, acc2);
        check("t2_cs_low_len", cs_low_len, CS_SETUP + 16 * CLK_DIV + CS_HOLD);
        check("t2_gap_at_least_idle", 32'((acc2 - cs_rise_cyc) >= CS_IDLE), 1);
        check("t2_rise_count", rise_cnt - base_r, 8);
        check("t2_first_rise_delay", rise_cyc[base_r % 64] - acc1, CS_SETUP + CLK_DIV);
        bad = 0;
        for (int i = 1; i < 8; i++)
            if (rise_cyc[(base_r + i) % 64] - rise_cyc[(base_r + i - 1) % 64] != 2 * CLK_DIV) bad++;
        check("t2_sclk_period_errs", bad, 0);
        check("t2_mosi_byte", mosi_byte(base_r), 8'h9F);
        check("t2_rx_pulses", rx_cnt - base_x, 1);
        check("t2_rx_data", rx_log[base_x % 64], 8'hA5);
        wait_idle("t2_second_done");
        check("t2_rx2_data", rx_log[(base_x + 1) % 64], 8'h5C);
        check("t2_mosi_byte2", mosi_byte(base_r + 8), 8'h05);

        // READ 0x03 + 3 address bytes + 4 data bytes in one CS window
        for (int i = 0; i < 4; i++) resp[i] = 8'hFF;
        resp[4]   = 8'h12;
        resp[5]   = 8'h34;
        resp[6]   = 8'h56;
        resp[7]   = 8'h78;
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        base_x    = rx_cnt;
        f0        = cs_fall_n;
        send(8'h03, 1'b0, acc1);
        for (int i = 0; i < 6; i++) send(8'h00, 1'b0, acc1);
        send(8'h00, 1'b1, acc1);
        wait_idle("t3_done");
        check("t3_single_cs_window", cs_fall_n - f0, 1);
        check("t3_rise_count", rise_cnt - base_r, 64);
        check("t3_rx_pulses", rx_cnt - base_x, 8);
        check("t3_mosi_cmd", mosi_byte(base_r), 8'h03);
        check("t3_rx_addr_phase", rx_log[base_x % 64], 8'hFF);
        check("t3_rx_d0", rx_log[(base_x + 4) % 64], 8'h12);
        check("t3_rx_d1", rx_log[(base_x + 5) % 64], 8'h34);
        check("t3_rx_d2", rx_log[(base_x + 6) % 64], 8'h56);
        check("t3_rx_d3", rx_log[(base_x + 7) % 64], 8'h78);

        // WREN 0x06 left open, then end_req wins over a simultaneous cmd_valid
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        base_x    = rx_cnt;
        send(8'h06, 1'b0, acc1);
        n = 0;
        while (rx_cnt == base_x && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_byte_done_in_time", 32'(n < 500), 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0) bad++;
        end
        check("t4_wait_pins_errs", bad, 0);
        check("t4_wait_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hAA;
        bus.cmd_last  = 1'b0;
        bus.end_req   = 1'b1;
        #1;
        check("t4_ready_blocked_by_end_req", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        h_edge        = cyc;
        bus.cmd_valid = 1'b0;
        bus.end_req   = 1'b0;
        wait_idle("t4_done");
        check("t4_cs_hold", cs_rise_cyc - h_edge, CS_HOLD);
        check("t4_no_second_byte", rise_cnt - base_r, 8);
        check("t4_rx_pulses", rx_cnt - base_x, 1);

        // Reset during the high phase of the 4th bit
        resp[0]   = 8'h81;
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        base_x    = rx_cnt;
        send(8'hC3, 1'b1, acc1);
        n = 0;
        while ((rise_cnt - base_r) < 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_bit4", 32'(n < 500), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_cs_n", spi_cs_n, 1);
        check("t5_rst_sclk", spi_sclk, 0);
        check("t5_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_rx_pulse", rx_cnt - base_x, 0);
        resp[0]   = 8'h3C;
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        base_x    = rx_cnt;
        send(8'h5A, 1'b1, acc1);
        wait_idle("t5_clean_done");
        check("t5_clean_mosi", mosi_byte(base_r), 8'h5A);
        check("t5_clean_rx", rx_log[base_x % 64], 8'h3C);

        // Write-protect pin around a WRSR transaction
        @(negedge clk);
        wp_en = 1'b1;
        #1;
        check("t6_wp_n_before_edge", spi_wp_n, 1);
        @(posedge clk);
        #1;
        check("t6_wp_n_after_edge", spi_wp_n, 0);
        resp[0]   = 8'hFF;
        resp[1]   = 8'hFF;
        fall_base = fall_cnt;
        base_r    = rise_cnt;
        f0        = cs_fall_n;
        send(8'h01, 1'b0, acc1);
        wp_en = 1'b0;
        #1;
        check("t6_wp_n_hold_mid", spi_wp_n, 0);
        @(posedge clk);
        #1;
        check("t6_wp_n_release_mid", spi_wp_n, 1);
        send(8'h02, 1'b1, acc1);
        wait_idle("t6_done");
        check("t6_mosi_cmd", mosi_byte(base_r), 8'h01);
        check("t6_mosi_sr", mosi_byte(base_r + 8), 8'h02);
        check("t6_single_cs_window", cs_fall_n - f0, 1);
        check("t6_hold_n_never_low", hold_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
